// File: rtl/decoder_pkg.sv
// Shared decoder types, default fixed-point format and the round/saturate helper.
package decoder_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_e;

  localparam int BITSIZE_DEF   = 32;
  localparam int FRAC_BITS_DEF = 27;
  localparam int RS_W          = 128;

  function automatic int acc_width(input int bw, input int n);
    return 2 * bw + $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   clip;
  } rs_t;

  // Wide-input helper so any decoder block can reuse it regardless of its word size.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc, input int frac, input int bw);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t res;
    one = {{(RS_W-1){1'b0}}, 1'b1};
    r   = acc;
    if (frac > 0) r = (acc + (one <<< (frac - 1))) >>> frac;
    hi       = (one <<< (bw - 1)) - one;
    lo       = -(one <<< (bw - 1));
    res.val  = r;
    res.clip = 1'b0;
    if (r > hi) begin
      res.val  = hi;
      res.clip = 1'b1;
    end else if (r < lo) begin
      res.val  = lo;
      res.clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_mac_unit.sv
// Single multiply-accumulate lane with bias preload, rounding and saturation.
// Optional ReLU on the written word via DECODER_SEQ_RELU_EN.
module decoder_mac_unit
  import decoder_pkg::*;
#(
  parameter int BITSIZE   = BITSIZE_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int N_INPUT   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_bias_i,
  input  logic                      accum_i,
  input  logic                      write_i,
  input  logic signed [BITSIZE-1:0] z_i,
  input  logic signed [BITSIZE-1:0] w_i,
  input  logic signed [BITSIZE-1:0] bias_i,
  output logic signed [BITSIZE-1:0] result_o,
  output logic                      clip_o
);

  localparam int ACC_W = acc_width(BITSIZE, N_INPUT);

  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [2*BITSIZE-1:0] prod;
  rs_t                         rs;
  logic                        unused_hi;

  assign prod = z_i * w_i;

  // A write cycle also reloads the next neuron's bias so MAC never stalls.
  always_comb begin
    acc_d = acc_q;
    if (load_bias_i || write_i) acc_d = ACC_W'(bias_i) <<< FRAC_BITS;
    else if (accum_i)           acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign rs        = round_sat(RS_W'(acc_q), FRAC_BITS, BITSIZE);
  assign clip_o    = rs.clip;
  assign unused_hi = ^rs.val[RS_W-1:BITSIZE];

`ifdef DECODER_SEQ_RELU_EN
  assign result_o = rs.val[RS_W-1] ? '0 : rs.val[BITSIZE-1:0];
`else
  assign result_o = rs.val[BITSIZE-1:0];
`endif

endmodule

// File: rtl/decoder_mac_seq.sv
// Sequential decoder layer: time-multiplexed MAC over N_INPUT x M_OUTPUT weights.
// DECODER_SEQ_RELU_EN (in decoder_mac_unit) clamps negative results to zero.
module decoder_mac_seq
  import decoder_pkg::*;
#(
  parameter int N_INPUT   = 2,
  parameter int M_OUTPUT  = 9,
  parameter int BITSIZE   = BITSIZE_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]          z,
  input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w,
  input  logic [M_OUTPUT*BITSIZE-1:0]         b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]         out,
  output logic [M_OUTPUT-1:0]                 sat_flags,
  output logic                                busy
);

  localparam int IW = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
  localparam int JW = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;

  state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic          wr_q, wr_d;
  logic          load_bias, accum, write, capture;
  logic [JW-1:0] bidx;

  logic [N_INPUT*BITSIZE-1:0]          z_q;
  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w_q;
  logic [M_OUTPUT*BITSIZE-1:0]         b_q;
  logic [M_OUTPUT*BITSIZE-1:0]         out_q;
  logic [M_OUTPUT-1:0]                 sat_q;

  logic signed [BITSIZE-1:0] result;
  logic                      clip;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    wr_d      = wr_q;
    load_bias = 1'b0;
    accum     = 1'b0;
    write     = 1'b0;
    case (state_q)
      IDLE: if (in_valid) state_d = LOAD;
      LOAD: begin
        load_bias = 1'b1;
        i_d       = '0;
        j_d       = '0;
        wr_d      = 1'b0;
        state_d   = MAC;
      end
      MAC: begin
        if (wr_q) begin
          write = 1'b1;
          wr_d  = 1'b0;
          i_d   = '0;
          if (j_q == JW'(M_OUTPUT - 1)) state_d = DONE;
          else                          j_d     = j_q + JW'(1);
        end else begin
          accum = 1'b1;
          if (i_q == IW'(N_INPUT - 1)) begin
            i_d  = '0;
            wr_d = 1'b1;
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wr_q    <= wr_d;
    end
  end

  assign capture = in_ready && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q <= '0;
      w_q <= '0;
      b_q <= '0;
    end else if (capture) begin
      z_q <= z;
      w_q <= w;
      b_q <= b;
    end
  end

  // On the last write there is no next bias; index 0 keeps the select in range.
  assign bidx = (write && (j_q != JW'(M_OUTPUT - 1))) ? j_q + JW'(1) : '0;

  decoder_mac_unit #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS),
    .N_INPUT  (N_INPUT)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .load_bias_i(load_bias),
    .accum_i    (accum),
    .write_i    (write),
    .z_i        (z_q[i_q*BITSIZE +: BITSIZE]),
    .w_i        (w_q[(j_q*N_INPUT + i_q)*BITSIZE +: BITSIZE]),
    .bias_i     (b_q[bidx*BITSIZE +: BITSIZE]),
    .result_o   (result),
    .clip_o     (clip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      sat_q <= '0;
    end else if (write) begin
      out_q[j_q*BITSIZE +: BITSIZE] <= result;
      sat_q[j_q]                    <= clip;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == LOAD) || (state_q == MAC);
  assign out       = out_q;
  assign sat_flags = sat_q;

endmodule

// File: tb/tb_decoder_mac_seq.sv
// Directed bench for decoder_mac_seq with hand-computed Q4.27 expectations.
module tb_decoder_mac_seq;

  localparam int N  = 2;
  localparam int M  = 9;
  localparam int BW = 32;
  localparam int LAT = M * (N + 1) + 1;
`ifdef DECODER_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [N*BW-1:0]   z = '0;
  logic [N*M*BW-1:0] w = '0;
  logic [M*BW-1:0]   b = '0;
  logic [M*BW-1:0]   out;
  logic [M-1:0]      sat_flags;

  logic [BW-1:0] zv [N];
  logic [BW-1:0] wv [N][M];
  logic [BW-1:0] bv [M];

  int pass_cnt = 0;
  int total    = 0;

  decoder_mac_seq #(.N_INPUT(N), .M_OUTPUT(M), .BITSIZE(BW), .FRAC_BITS(27)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .w(w), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .sat_flags(sat_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clear_vec();
    for (int i = 0; i < N; i++) zv[i] = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < M; j++) wv[i][j] = '0;
    for (int j = 0; j < M; j++) bv[j] = '0;
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) z[i*BW +: BW] = zv[i];
    for (int j = 0; j < M; j++) for (int i = 0; i < N; i++) w[(j*N+i)*BW +: BW] = wv[i][j];
    for (int j = 0; j < M; j++) b[j*BW +: BW] = bv[j];
  endtask

  task automatic basic_vec();
    clear_vec();
    zv[0] = 32'hF800_0000; zv[1] = 32'h0800_0000;
    wv[0][0] = 32'h0800_0000; wv[1][0] = 32'h0800_0000; bv[0] = 32'hF800_0000;
    wv[1][1] = 32'h1000_0000; bv[1] = 32'h0400_0000;
    wv[0][2] = 32'h0800_0000;
  endtask

  function automatic logic [BW-1:0] exp_basic(input int j);
    case (j)
      0, 2:    return RELU ? 32'h0 : 32'hF800_0000;
      1:       return 32'h1400_0000;
      default: return 32'h0;
    endcase
  endfunction

  // Handshake the current vectors in and return cycles until out_valid (-1 on timeout).
  task automatic start_txn(output int lat);
    int guard;
    pack_inputs();
    @(negedge clk);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_txn();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    total++;
    if ({out_valid, busy} !== 2'b00) $display("FAIL reset_valid_busy got=%b exp=00", {out_valid, busy}); else pass_cnt++;
    total++;
    if (out !== '0 || sat_flags !== '0) $display("FAIL reset_out got=%h sat=%h exp=0", out, sat_flags); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    basic_vec();
    start_txn(lat);
    total++;
    if (lat !== LAT) $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      total++;
      if (out[j*BW +: BW] !== exp_basic(j))
        $display("FAIL basic_out%0d got=%h exp=%h", j, out[j*BW +: BW], exp_basic(j));
      else pass_cnt++;
    end
    total++;
    if (sat_flags !== '0) $display("FAIL basic_sat got=%h exp=0", sat_flags); else pass_cnt++;
    finish_txn();
  endtask

  task automatic test_saturation();
    int lat;
    logic [BW-1:0] exp_neg;
    clear_vec();
    zv[0] = 32'h7800_0000;
    for (int j = 0; j < M; j++) wv[0][j] = 32'h7800_0000;
    start_txn(lat);
    for (int j = 0; j < M; j++) begin
      total++;
      if (out[j*BW +: BW] !== 32'h7FFF_FFFF)
        $display("FAIL pos_sat_out%0d got=%h exp=7fffffff", j, out[j*BW +: BW]);
      else pass_cnt++;
    end
    total++;
    if (sat_flags !== 9'h1FF) $display("FAIL pos_sat_flags got=%h exp=1ff", sat_flags); else pass_cnt++;
    finish_txn();
    for (int j = 0; j < M; j++) wv[0][j] = 32'h8800_0000;
    exp_neg = RELU ? 32'h0 : 32'h8000_0000;
    start_txn(lat);
    for (int j = 0; j < M; j += 4) begin
      total++;
      if (out[j*BW +: BW] !== exp_neg)
        $display("FAIL neg_sat_out%0d got=%h exp=%h", j, out[j*BW +: BW], exp_neg);
      else pass_cnt++;
    end
    total++;
    if (sat_flags !== 9'h1FF) $display("FAIL neg_sat_flags got=%h exp=1ff", sat_flags); else pass_cnt++;
    finish_txn();
  endtask

  task automatic test_rounding();
    int lat;
    clear_vec();
    zv[0] = 32'h0000_0001; wv[0][0] = 32'h0400_0000;
    start_txn(lat);
    total++;
    if (out[BW-1:0] !== 32'h1) $display("FAIL round_half_up got=%h exp=00000001", out[BW-1:0]); else pass_cnt++;
    total++;
    if (sat_flags !== '0) $display("FAIL round_sat got=%h exp=0", sat_flags); else pass_cnt++;
    finish_txn();
    zv[0] = 32'hFFFF_FFFF;
    start_txn(lat);
    total++;
    if (out[BW-1:0] !== 32'h0) $display("FAIL round_neg_half got=%h exp=00000000", out[BW-1:0]); else pass_cnt++;
    finish_txn();
  endtask

  task automatic test_backpressure();
    int lat;
    basic_vec();
    start_txn(lat);
    total++;
    if (lat !== LAT) $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); else pass_cnt++;
    zv[0] = 32'h0800_0000;
    pack_inputs();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out[BW +: BW] !== exp_basic(1) || out[BW-1:0] !== exp_basic(0))
        $display("FAIL bp_hold_c%0d valid=%b ready=%b out0=%h out1=%h exp=1 0 %h %h",
                 c, out_valid, in_ready, out[BW-1:0], out[BW +: BW], exp_basic(0), exp_basic(1));
      else pass_cnt++;
    end
    total++;
    if (sat_flags !== '0) $display("FAIL bp_sat got=%h exp=0", sat_flags); else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release ready=%b valid=%b exp=1 0", in_ready, out_valid);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL bp_single_transfer busy=%b valid=%b exp=0 0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mac();
    int lat;
    clear_vec();
    zv[0] = 32'h0000_0001; wv[0][0] = 32'h0400_0000;
    pack_inputs();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out !== '0 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL mid_reset valid=%b busy=%b ready=%b out=%h exp=0 0 0 0", out_valid, busy, in_ready, out);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    basic_vec();
    start_txn(lat);
    total++;
    if (lat !== LAT) $display("FAIL mid_reset_latency got=%0d exp=%0d", lat, LAT); else pass_cnt++;
    total++;
    if (out[BW +: BW] !== exp_basic(1) || out[BW-1:0] !== exp_basic(0))
      $display("FAIL mid_reset_result out0=%h out1=%h exp=%h %h", out[BW-1:0], out[BW +: BW], exp_basic(0), exp_basic(1));
    else pass_cnt++;
    finish_txn();
  endtask

  initial begin
    clear_vec();
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
